// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for alu_share_arbiter: FSM state encoding, ALU control codes,
// default widths and an id-width helper.
package alu_share_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_t;

    localparam int unsigned DW_DEF = 32;
    localparam int unsigned CW_DEF = 4;
    localparam int unsigned WAIT_W = 4;

    localparam logic [CW_DEF-1:0] ALU_ADD = 4'd0;
    localparam logic [CW_DEF-1:0] ALU_SUB = 4'd1;
    localparam logic [CW_DEF-1:0] ALU_AND = 4'd2;
    localparam logic [CW_DEF-1:0] ALU_OR  = 4'd3;
    localparam logic [CW_DEF-1:0] ALU_XOR = 4'd4;
    localparam logic [CW_DEF-1:0] ALU_LUI = 4'd5;

    // Bits needed to name one of n requesters (at least 1).
    function automatic int unsigned id_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// Combinational round-robin picker: grants the first eligible index after rr_ptr,
// wrapping modulo NREQ.
module alu_share_arbiter_rr_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter  int unsigned NREQ = 2,
    localparam int unsigned IW   = id_width(NREQ)
) (
    input  logic [NREQ-1:0] elig,
    input  logic [IW-1:0]   rr_ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   grant_id
);

    logic [IW-1:0] w_idx;
    logic          w_found;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        w_found  = 1'b0;
        w_idx    = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            w_idx = IW'((32'(rr_ptr) + k) % NREQ);
            if (!w_found && elig[w_idx]) begin
                grant[w_idx] = 1'b1;
                grant_id     = w_idx;
                w_found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between NREQ requesters with round-robin arbitration
// and a one-entry result slot per requester. Optional macro: ALU_ARB_LOCK_EN.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int unsigned NREQ     = 2,
    parameter int unsigned DW       = DW_DEF,
    parameter int unsigned CW       = CW_DEF,
    parameter int unsigned ALU_WAIT = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [CW*NREQ-1:0] req_ctrl,
    input  logic [DW*NREQ-1:0] req_x,
    input  logic [DW*NREQ-1:0] req_y,
    output logic [NREQ-1:0]    rsp_valid,
    input  logic [NREQ-1:0]    rsp_ready,
    output logic [DW*NREQ-1:0] rsp_result,
    output logic [NREQ-1:0]    rsp_zero,
    output logic [DW-1:0]      alu_x,
    output logic [DW-1:0]      alu_y,
    output logic [CW-1:0]      alu_ctrl,
    input  logic [DW-1:0]      alu_result,
    input  logic               alu_zero,
`ifdef ALU_ARB_LOCK_EN
    input  logic [NREQ-1:0]    req_lock,
`endif
    output logic               busy
);

    localparam int unsigned IW = id_width(NREQ);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [IW-1:0]       r_rr_ptr;
    logic [IW-1:0]       r_owner;
    logic [WAIT_W-1:0]   r_wait;
    logic [DW-1:0]       r_x;
    logic [DW-1:0]       r_y;
    logic [CW-1:0]       r_ctrl;
    logic [NREQ-1:0]     r_rsp_valid;
    logic [NREQ-1:0]     r_rsp_zero;
    logic [DW*NREQ-1:0]  r_rsp_result;

    logic [NREQ-1:0]     w_elig;
    logic [NREQ-1:0]     w_grant;
    logic [IW-1:0]       w_grant_id;
    logic [NREQ-1:0]     w_pick;
    logic [IW-1:0]       w_pick_id;
    logic                w_accept;
    logic                w_capture;
    logic                w_ptr_hold;

    // A full slot that is not being popped blocks its requester.
    assign w_elig = req_valid & (~r_rsp_valid | rsp_ready);

    alu_share_arbiter_rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr (
        .elig     (w_elig),
        .rr_ptr   (r_rr_ptr),
        .grant    (w_grant),
        .grant_id (w_grant_id)
    );

`ifdef ALU_ARB_LOCK_EN
    logic r_lock;
    logic r_last_lock;

    // A locked owner of the last completed operation keeps the ALU while it is eligible.
    always_comb begin
        w_pick    = w_grant;
        w_pick_id = w_grant_id;
        if (r_last_lock && w_elig[r_owner]) begin
            w_pick          = '0;
            w_pick[r_owner] = 1'b1;
            w_pick_id       = r_owner;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lock      <= 1'b0;
            r_last_lock <= 1'b0;
        end else if (w_accept) begin
            r_lock      <= req_lock[w_pick_id];
        end else if (w_capture) begin
            r_last_lock <= r_lock;
        end
    end

    assign w_ptr_hold = r_lock;
`else
    assign w_pick     = w_grant;
    assign w_pick_id  = w_grant_id;
    assign w_ptr_hold = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (|w_elig) w_state_nxt = ST_EXEC;
            ST_EXEC: if (r_wait == '0) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output / control decode; grants are suppressed while reset is held.
    always_comb begin
        req_ready = '0;
        w_accept  = 1'b0;
        w_capture = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!rst && (|w_elig)) begin
                    req_ready = w_pick;
                    w_accept  = 1'b1;
                end
            end
            ST_EXEC: w_capture = (r_wait == '0);
            default: ;
        endcase
    end

    // Operand latch doubles as the ALU drive: loaded at accept, cleared at capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x      <= '0;
            r_y      <= '0;
            r_ctrl   <= '0;
            r_owner  <= '0;
            r_wait   <= '0;
            r_rr_ptr <= IW'(NREQ - 1);
        end else if (w_accept) begin
            r_x     <= req_x[32'(w_pick_id) * DW +: DW];
            r_y     <= req_y[32'(w_pick_id) * DW +: DW];
            r_ctrl  <= req_ctrl[32'(w_pick_id) * CW +: CW];
            r_owner <= w_pick_id;
            r_wait  <= WAIT_W'(ALU_WAIT);
        end else if (w_capture) begin
            r_x    <= '0;
            r_y    <= '0;
            r_ctrl <= '0;
            if (!w_ptr_hold) begin
                r_rr_ptr <= r_owner;
            end
        end else if (r_state == ST_EXEC) begin
            r_wait <= r_wait - 1'b1;
        end
    end

    // Per-requester result slots; a capture never meets a full slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_valid  <= '0;
            r_rsp_result <= '0;
            r_rsp_zero   <= '0;
        end else begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (w_capture && (32'(r_owner) == i)) begin
                    r_rsp_valid[i]            <= 1'b1;
                    r_rsp_result[i*DW +: DW]  <= alu_result;
                    r_rsp_zero[i]             <= alu_zero;
                end else if (r_rsp_valid[i] && rsp_ready[i]) begin
                    r_rsp_valid[i] <= 1'b0;
                end
            end
        end
    end

    assign rsp_valid  = r_rsp_valid;
    assign rsp_result = r_rsp_result;
    assign rsp_zero   = r_rsp_zero;
    assign alu_x      = r_x;
    assign alu_y      = r_y;
    assign alu_ctrl   = r_ctrl;
    assign busy       = (r_state == ST_EXEC);

endmodule
